memif_initiator: RTL
====================

MEMIF_INITIATOR -- requirements
Module: memif_initiator

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, max cycles req may wait for gnt before abort (1..65535).
REQ-002 g_clk  input  1  gated clock; sole clock.
REQ-003 g_resetn  input  1  asynchronous active-low reset.
REQ-004 g_clk_req  output  1  clock request.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when valid&&ready.
REQ-007 cmd_wen  input  1  1=write, 0=read.
REQ-008 cmd_strb  input  4  write byte strobes.
REQ-009 cmd_addr  input  32  byte address.
REQ-010 cmd_wdata  input  32  write data.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  response consumed when valid&&ready.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 rsp_error  output  1  bus error or timeout.
REQ-015 memif  scarv_ccx_memif.REQ  -  requester end: drives req, wen, strb, addr, wdata; samples gnt, rdata, error.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, RSP; encoding free.
REQ-017 cmd_ready SHALL be 1 only in IDLE.
REQ-018 IDLE->REQ on cmd_valid&&cmd_ready; wen/strb/addr/wdata registered that cycle.
REQ-019 memif.req SHALL be 1 exactly while in REQ; wen/strb/addr/wdata SHALL be stable throughout REQ.
REQ-020 In REQ, gnt=1 completes the transaction that cycle: capture memif.error and (reads only, error=0) memif.rdata; go to RSP.
REQ-021 Writes SHALL capture rsp_rdata=0; erroring reads SHALL capture rsp_rdata=0.
REQ-022 rsp_valid SHALL be 1 exactly in RSP; rsp_rdata/rsp_error stable while rsp_valid.
REQ-023 RSP->IDLE on rsp_ready; rsp_ready ignored outside RSP.
REQ-024 Latency: command accepted at cycle N -> req high at N+1; gnt at cycle M -> rsp_valid at M+1; zero-wait gnt gives rsp_valid at N+2.
REQ-025 No new command SHALL be accepted in the cycle rsp handshake completes (IDLE reached next cycle).
REQ-026 memif.strb SHALL be driven 4'b0000 for reads regardless of cmd_strb.
REQ-027 g_clk_req SHALL be (state!=IDLE)||cmd_valid.
REQ-028 gnt, rdata, error outside REQ SHALL be ignored.

Reset
REQ-029 g_resetn low SHALL asynchronously force IDLE, req=0, wen=0, strb=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, timeout counter=0.
REQ-030 Reset asserted mid-REQ or mid-RSP SHALL drop req/rsp_valid immediately; the in-flight transaction is discarded, no response produced.
REQ-031 After release, cmd_ready SHALL be 1 on the first clock edge.

Configuration
REQ-032 Macro MEMIF_INITIATOR_TIMEOUT_EN SHALL compile in a 16-bit wait counter.
REQ-033 With macro: counter clears on entering REQ, increments each REQ cycle with gnt=0; when it equals TIMEOUT_CYCLES and gnt=0, req drops, go to RSP with rsp_error=1, rsp_rdata=0.
REQ-034 gnt arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL win (normal completion).
REQ-035 Without macro: no counter logic; REQ waits for gnt indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-036 Read addr=0x0000_1000, gnt same cycle req rises, rdata=0xDEAD_BEEF -> rsp_valid 2 cycles after accept, rdata=0xDEAD_BEEF, error=0.
REQ-037 Write addr=0x10, wdata=0x1234_5678, strb=0x3, gnt after 5 wait cycles -> req/addr/wdata/strb stable 6 cycles, rsp rdata=0, error=0.
REQ-038 Read with error=1 at gnt and rdata=0xFFFF_FFFF -> rsp_error=1, rsp_rdata=0.
REQ-039 rsp_ready low 10 cycles with cmd_valid high -> cmd_ready stays 0, rsp fields stable; second command accepted one cycle after rsp handshake.
REQ-040 With MEMIF_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never -> req high exactly 5 cycles, then rsp_error=1; repeat with gnt on 5th cycle -> error=0.
REQ-041 Assert g_resetn low mid-REQ -> req and cmd_ready-state reset same cycle asynchronously; no rsp_valid after release.

Source files
------------

// File: rtl/memif_initiator_if.sv
// Memory-interface bundle between a requester and a memory/bus target.
// The requester drives the command fields; the target answers with gnt, rdata and error.
interface scarv_ccx_memif;
    logic        req;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic [31:0] rdata;
    logic        error;

    modport REQ (output req, wen, strb, addr, wdata, input gnt, rdata, error);
    modport RSP (input req, wen, strb, addr, wdata, output gnt, rdata, error);
endinterface

// File: rtl/memif_initiator.sv
// Single-outstanding command-to-memif bridge with a held response register.
// Define MEMIF_INITIATOR_TIMEOUT_EN to abort requests that wait TIMEOUT_CYCLES without gnt.
module memif_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    output logic        g_clk_req,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wen,
    input  logic [3:0]  cmd_strb,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    scarv_ccx_memif.REQ memif
);

    // state  | meaning
    // IDLE   | ready for a command
    // REQ    | request on memif, waiting for gnt (or timeout)
    // RSP    | response held until rsp_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("memif_initiator: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t      state;
    state_t      state_nxt;
    logic        wen_q;
    logic [3:0]  strb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        timeout;
    logic        accept;

    assign accept    = (state == ST_IDLE) && cmd_valid;
    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RSP);
    assign g_clk_req = (state != ST_IDLE) || cmd_valid;

    assign memif.req   = (state == ST_REQ);
    assign memif.wen   = wen_q;
    assign memif.strb  = strb_q;
    assign memif.addr  = addr_q;
    assign memif.wdata = wdata_q;

`ifdef MEMIF_INITIATOR_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // gnt in the terminal cycle takes priority over the abort.
    assign timeout = (state == ST_REQ) && !memif.gnt && (wait_cnt == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wait_cnt <= 16'd0;
        end else if (state != ST_REQ) begin
            wait_cnt <= 16'd0;
        end else if (!memif.gnt) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid)              state_nxt = ST_REQ;
            ST_REQ:  if (memif.gnt || timeout)   state_nxt = ST_RSP;
            ST_RSP:  if (rsp_ready)              state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wen_q     <= 1'b0;
            strb_q    <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            if (accept) begin
                wen_q   <= cmd_wen;
                strb_q  <= cmd_wen ? cmd_strb : 4'd0;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (state == ST_REQ) begin
                if (memif.gnt) begin
                    rsp_error <= memif.error;
                    rsp_rdata <= (!wen_q && !memif.error) ? memif.rdata : 32'd0;
                end else if (timeout) begin
                    rsp_error <= 1'b1;
                    rsp_rdata <= 32'd0;
                end
            end
        end
    end

endmodule
